topk_doc_selector: RTL and testbench
====================================

// Module: topk_doc_selector
// PURPOSE
// - Upstream of text_buffer_manager: consumes the retrieval candidate stream (id, score, length).
// - Keeps the TOP_K best candidates, sorted by score.
// - Runs a budget pass that yields the doc_included mask and per-rank lengths for the augmentation stage.
// - Keeps the assembled prompt (query + "\n\n" + docs with "\n\n") inside token_budget.
// PARAMETERS
// - TOP_K            5    retained candidates (ranks 0..TOP_K-1, rank 0 = best)
// - MAX_SEQUENCE_LEN 512  per-document length clamp
// - SCORE_W          32   unsigned score width
// - ID_W             16   document id width
// PORTS
// - clk             in   1        clock
// - rst_n           in   1        reset, asynchronous, active-low
// - start           in   1        begin selection (sampled in IDLE only)
// - score_threshold in   SCORE_W  minimum score for inclusion, latched at start
// - token_budget    in   32       total output byte budget, latched at start
// - query_length    in   32       query bytes, latched at start
// - cand_valid      in   1        candidate beat valid
// - cand_ready      out  1        high only in COLLECT
// - cand_id         in   ID_W     document id
// - cand_score      in   SCORE_W  similarity score
// - cand_length     in   32       document byte length
// - cand_last       in   1        final candidate beat
// - sel_ids         out  [TOP_K][ID_W]     ranked ids
// - sel_scores      out  [TOP_K][SCORE_W]  ranked scores (feeds similarity_scores)
// - sel_lengths     out  [TOP_K][32]       clamped lengths (feeds doc_lengths)
// - num_valid       out  $clog2(TOP_K+1)   occupied ranks
// - doc_included    out  TOP_K    inclusion mask (feeds doc_included)
// - busy            out  1        not IDLE
// - done            out  1        one-cycle pulse; results stable until next start
// BEHAVIOUR
// - Reset: all outputs 0, table empty, state IDLE.
// - States:
//   - IDLE    -start->        COLLECT: clear table, num_valid, mask; latch threshold, budget, query_length.
//   - COLLECT -accepted last-> BUDGET: one beat accepted per cycle when cand_valid & cand_ready.
//   - BUDGET  -TOP_K cycles->  DONE: rank idx = 0..TOP_K-1.
//   - DONE    -1 cycle->       IDLE: done=1 in this cycle only.
// - Insert (single cycle): p = count of valid entries with score >= cand_score (ties keep earlier arrival ahead).
//   - If p < TOP_K: ranks p..TOP_K-2 shift down one, new entry written at p, the old TOP_K-1 entry is dropped.
//   - num_valid saturates at TOP_K. If p == TOP_K, the candidate is discarded.
// - Length clamp at insert: stored length = min(cand_length, MAX_SEQUENCE_LEN).
// - Budget pass: 33-bit accumulator used, initialised to query_length + SEP_LEN.
//   - For rank idx: include iff idx < num_valid && score >= threshold && used + len + SEP_LEN <= token_budget.
//   - If included: used += len + SEP_LEN.
//   - An excluded rank does not end the walk; a later shorter doc may still fit.
// - If query_length + SEP_LEN > token_budget, the mask is all 0.
// - Latency: last beat accepted in cycle c -> BUDGET c+1..c+TOP_K -> done at c+TOP_K+1.
// - start while busy is ignored. cand_valid outside COLLECT is not accepted (cand_ready=0).
// - A beat with cand_last=0 and cand_valid=0 has no effect; the stream holds at least 1 beat.
// - Asynchronous reset mid-operation aborts to IDLE and clears all outputs; no done is issued.
// - Outputs sel_* and doc_included change only in COLLECT/BUDGET and hold after DONE.
// STRUCTURE
// - rag_csd_pkg: selector state enum (SEL_IDLE, SEL_COLLECT, SEL_BUDGET, SEL_DONE), SEP_LEN = 2,
//   and a cand_entry_t struct {id, score, length}.
// - Sub-module topk_insert_sorter: holds the entry array, position compare, and shift-insert;
//   exposes clear, insert_valid, entries, and num_valid.
// - The parent owns the FSM, latched config, budget accumulator, and mask.
// TESTING
// 1. Ordering: TOP_K=5; scores 10,50,30,70,20,60,40 (last on 7th) -> sel_scores 70,60,50,40,30; num_valid=5.
// 2. Ties: three beats score 25, ids 1,2,3 -> sel_ids 1,2,3 in ranks 0..2.
// 3. Budget: query_length=100, budget=400, lengths 150,200,80 with scores 9,8,7, threshold 0
//    -> used 102, +152=254 incl, 456 excl, +82=336 incl -> mask 5'b00101.
// 4. Threshold & clamp: threshold 50, scores 60,40, length 1000 -> sel_lengths[0]=512, mask 5'b00001 (budget 4096).
// 5. Short stream: single beat with last -> num_valid=1, done exactly TOP_K+1 cycles after the beat.
//    Ranks 1..4 excluded.
// 6. Robustness: start during BUDGET ignored; rst_n low mid-COLLECT -> all outputs 0, no done.
//    Fresh start then runs cleanly.

Source files
------------

// File: rtl/rag_csd_pkg.sv
// Shared types for the retrieval candidate selector.
// State enum, separator length, and the stored candidate entry.
package rag_csd_pkg;

  localparam int SEP_LEN      = 2;
  localparam int CAND_ID_W    = 16;
  localparam int CAND_SCORE_W = 32;
  localparam int CAND_LEN_W   = 32;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_COLLECT,
    SEL_BUDGET,
    SEL_DONE
  } sel_state_e;

  typedef struct packed {
    logic [CAND_ID_W-1:0]    id;
    logic [CAND_SCORE_W-1:0] score;
    logic [CAND_LEN_W-1:0]   length;
  } cand_entry_t;

endpackage

// File: rtl/topk_insert_sorter.sv
// Sorted top-K table with single-cycle shift-insert.
// Ports: clear, insert_valid/insert_entry in; entries, num_valid out.
module topk_insert_sorter
  import rag_csd_pkg::*;
#(
  parameter int TOP_K = 5,
  parameter int NV_W  = $clog2(TOP_K + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      insert_valid,
  input  cand_entry_t               insert_entry,
  output cand_entry_t [TOP_K-1:0]   entries,
  output logic        [NV_W-1:0]    num_valid
);

  cand_entry_t [TOP_K-1:0] ent_q, ent_d;
  logic [NV_W-1:0]         nv_q, nv_d;
  logic [TOP_K-1:0]        ahead;
  logic [NV_W-1:0]         pos;

  // Equal scores count as ahead, so earlier arrivals keep their rank.
  always_comb begin
    pos   = '0;
    ahead = '0;
    for (int i = 0; i < TOP_K; i++) begin
      ahead[i] = (NV_W'(i) < nv_q) &&
                 (ent_q[i].score >= insert_entry.score);
      pos = pos + NV_W'(ahead[i]);
    end
  end

  always_comb begin
    ent_d = ent_q;
    nv_d  = nv_q;
    if (clear) begin
      ent_d = '0;
      nv_d  = '0;
    end else if (insert_valid && (pos < NV_W'(TOP_K))) begin
      for (int i = 1; i < TOP_K; i++) begin
        if (NV_W'(i) > pos) begin
          ent_d[i] = ent_q[i-1];
        end
      end
      for (int i = 0; i < TOP_K; i++) begin
        if (NV_W'(i) == pos) begin
          ent_d[i] = insert_entry;
        end
      end
      if (nv_q != NV_W'(TOP_K)) begin
        nv_d = nv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      nv_q  <= '0;
    end else begin
      ent_q <= ent_d;
      nv_q  <= nv_d;
    end
  end

  assign entries   = ent_q;
  assign num_valid = nv_q;

endmodule

// File: rtl/topk_doc_selector.sv
// Keeps the best TOP_K retrieval candidates and builds the inclusion mask.
// Ports: start/config in, cand_* stream in, sel_*/num_valid/mask/busy/done out.
module topk_doc_selector
  import rag_csd_pkg::*;
#(
  parameter int TOP_K            = 5,
  parameter int MAX_SEQUENCE_LEN = 512,
  parameter int SCORE_W          = CAND_SCORE_W,
  parameter int ID_W             = CAND_ID_W,
  parameter int NV_W             = $clog2(TOP_K + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [SCORE_W-1:0]              score_threshold,
  input  logic [31:0]                     token_budget,
  input  logic [31:0]                     query_length,
  input  logic                            cand_valid,
  output logic                            cand_ready,
  input  logic [ID_W-1:0]                 cand_id,
  input  logic [SCORE_W-1:0]              cand_score,
  input  logic [31:0]                     cand_length,
  input  logic                            cand_last,
  output logic [TOP_K-1:0][ID_W-1:0]      sel_ids,
  output logic [TOP_K-1:0][SCORE_W-1:0]   sel_scores,
  output logic [TOP_K-1:0][31:0]          sel_lengths,
  output logic [NV_W-1:0]                 num_valid,
  output logic [TOP_K-1:0]                doc_included,
  output logic                            busy,
  output logic                            done
);

  sel_state_e                state_q, state_d;
  logic [CAND_SCORE_W-1:0]   thr_q, thr_d;
  logic [31:0]               budget_q, budget_d;
  logic [32:0]               used_q, used_d;
  logic [NV_W-1:0]           idx_q, idx_d;
  logic [TOP_K-1:0]          mask_q, mask_d;

  logic                      srt_clear;
  logic                      srt_ins;
  cand_entry_t               ins_entry;
  cand_entry_t [TOP_K-1:0]   entries;
  logic [NV_W-1:0]           nv;

  cand_entry_t               cur;
  logic [33:0]               need;
  logic                      incl;
  logic [31:0]               len_clamp;

  assign len_clamp =
    (cand_length > 32'(MAX_SEQUENCE_LEN)) ?
    32'(MAX_SEQUENCE_LEN) : cand_length;

  always_comb begin
    ins_entry        = '0;
    ins_entry.id     = CAND_ID_W'(cand_id);
    ins_entry.score  = CAND_SCORE_W'(cand_score);
    ins_entry.length = len_clamp;
  end

  topk_insert_sorter #(
    .TOP_K (TOP_K),
    .NV_W  (NV_W)
  ) u_sorter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (srt_clear),
    .insert_valid (srt_ins),
    .insert_entry (ins_entry),
    .entries      (entries),
    .num_valid    (nv)
  );

  // Budget walk: one rank per cycle; the accumulator only grows, so a
  // query that already overflows the budget leaves every rank excluded.
  always_comb begin
    cur = '0;
    for (int i = 0; i < TOP_K; i++) begin
      if (NV_W'(i) == idx_q) begin
        cur = entries[i];
      end
    end
    need = 34'(used_q) + 34'(cur.length) + 34'(SEP_LEN);
    incl = (idx_q < nv) &&
           (cur.score >= thr_q) &&
           (need <= 34'(budget_q));
  end

  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    budget_d  = budget_q;
    used_d    = used_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    srt_clear = 1'b0;
    srt_ins   = 1'b0;
    unique case (state_q)
      SEL_IDLE: begin
        if (start) begin
          state_d   = SEL_COLLECT;
          srt_clear = 1'b1;
          mask_d    = '0;
          thr_d     = CAND_SCORE_W'(score_threshold);
          budget_d  = token_budget;
          used_d    = 33'(query_length) + 33'(SEP_LEN);
          idx_d     = '0;
        end
      end
      SEL_COLLECT: begin
        if (cand_valid) begin
          srt_ins = 1'b1;
          if (cand_last) begin
            state_d = SEL_BUDGET;
          end
        end
      end
      SEL_BUDGET: begin
        if (incl) begin
          used_d = 33'(need);
          for (int i = 0; i < TOP_K; i++) begin
            if (NV_W'(i) == idx_q) begin
              mask_d[i] = 1'b1;
            end
          end
        end
        if (idx_q == NV_W'(TOP_K - 1)) begin
          state_d = SEL_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEL_DONE: begin
        state_d = SEL_IDLE;
      end
      default: begin
        state_d = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEL_IDLE;
      thr_q    <= '0;
      budget_q <= '0;
      used_q   <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      budget_q <= budget_d;
      used_q   <= used_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    sel_ids     = '0;
    sel_scores  = '0;
    sel_lengths = '0;
    for (int i = 0; i < TOP_K; i++) begin
      sel_ids[i]     = ID_W'(entries[i].id);
      sel_scores[i]  = SCORE_W'(entries[i].score);
      sel_lengths[i] = entries[i].length;
    end
  end

  assign cand_ready   = (state_q == SEL_COLLECT);
  assign num_valid    = nv;
  assign doc_included = mask_q;
  assign busy         = (state_q != SEL_IDLE);
  assign done         = (state_q == SEL_DONE);

endmodule

// File: tb/tb_topk_doc_selector.sv
// Scoreboard bench for topk_doc_selector against a sort-based model.
// Directed ordering/tie/budget/clamp/robustness cases plus random streams.
module tb_topk_doc_selector;

  localparam int K = 5;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       score_threshold;
  logic [31:0]       token_budget;
  logic [31:0]       query_length;
  logic              cand_valid;
  logic              cand_ready;
  logic [15:0]       cand_id;
  logic [31:0]       cand_score;
  logic [31:0]       cand_length;
  logic              cand_last;
  logic [K-1:0][15:0] sel_ids;
  logic [K-1:0][31:0] sel_scores;
  logic [K-1:0][31:0] sel_lengths;
  logic [2:0]        num_valid;
  logic [K-1:0]      doc_included;
  logic              busy;
  logic              done;

  topk_doc_selector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .score_threshold (score_threshold),
    .token_budget    (token_budget),
    .query_length    (query_length),
    .cand_valid      (cand_valid),
    .cand_ready      (cand_ready),
    .cand_id         (cand_id),
    .cand_score      (cand_score),
    .cand_length     (cand_length),
    .cand_last       (cand_last),
    .sel_ids         (sel_ids),
    .sel_scores      (sel_scores),
    .sel_lengths     (sel_lengths),
    .num_valid       (num_valid),
    .doc_included    (doc_included),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     id;
    longint score;
    longint len;
  } tcand_t;

  typedef struct {
    logic [K-1:0][15:0] ids;
    logic [K-1:0][31:0] scores;
    logic [K-1:0][31:0] lens;
    int                 nv;
    logic [K-1:0]       mask;
    longint             done_cyc;
  } exp_t;

  exp_t   exp_q[$];
  tcand_t cs[$];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(string name, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: stable descending sort of all accepted candidates,
  // keep the first K, then walk ranks against the byte budget.
  function automatic exp_t model(input tcand_t c[$], input longint thr,
                                 input longint bud, input longint ql);
    exp_t   e;
    tcand_t s[$];
    tcand_t t;
    longint used;
    int     j;
    s = c;
    for (int i = 1; i < s.size(); i++) begin
      j = i;
      while (j > 0 && s[j-1].score < s[j].score) begin
        t = s[j-1]; s[j-1] = s[j]; s[j] = t;
        j--;
      end
    end
    e.ids = '0; e.scores = '0; e.lens = '0; e.mask = '0;
    e.nv = (s.size() < K) ? s.size() : K;
    e.done_cyc = 0;
    for (int r = 0; r < e.nv; r++) begin
      e.ids[r]    = 16'(s[r].id);
      e.scores[r] = 32'(s[r].score);
      e.lens[r]   = 32'((s[r].len > 512) ? 512 : s[r].len);
    end
    used = ql + 2;
    for (int r = 0; r < K; r++) begin
      if (r < e.nv && longint'(e.scores[r]) >= thr &&
          used + longint'(e.lens[r]) + 2 <= bud) begin
        e.mask[r] = 1'b1;
        used = used + longint'(e.lens[r]) + 2;
      end
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc, e.done_cyc);
          chk("num_valid", num_valid, e.nv);
          chk("mask", doc_included, e.mask);
          for (int r = 0; r < K; r++) begin
            chk($sformatf("id[%0d]", r), sel_ids[r], e.ids[r]);
            chk($sformatf("score[%0d]", r), sel_scores[r], e.scores[r]);
            chk($sformatf("len[%0d]", r), sel_lengths[r], e.lens[r]);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic do_start(input longint thr, input longint bud,
                          input longint ql);
    @(negedge clk);
    start = 1'b1;
    score_threshold = 32'(thr);
    token_budget = 32'(bud);
    query_length = 32'(ql);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input tcand_t c, input bit last,
                           input int gap, output longint acc);
    bit ok;
    ok = 0;
    @(negedge clk);
    cand_valid = 1'b0;
    repeat (gap) @(negedge clk);
    cand_valid  = 1'b1;
    cand_id     = 16'(c.id);
    cand_score  = 32'(c.score);
    cand_length = 32'(c.len);
    cand_last   = last;
    for (int k = 0; k < 50; k++) begin
      if (cand_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (last) begin
      cand_valid = 1'b0;
      cand_last  = 1'b0;
    end
  endtask

  task automatic run_txn(input longint thr, input longint bud,
                         input longint ql, input int maxgap,
                         input bit poke);
    exp_t   e;
    longint acc;
    int     g;
    wait_idle();
    do_start(thr, bud, ql);
    for (int i = 0; i < cs.size(); i++) begin
      g = (maxgap > 0 && $urandom_range(0, 2) == 0) ?
          int'($urandom_range(1, maxgap)) : 0;
      send_beat(cs[i], i == cs.size() - 1, g, acc);
    end
    e = model(cs, thr, bud, ql);
    e.done_cyc = acc + K;
    exp_q.push_back(e);
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      token_budget = 32'd0;
      score_threshold = 32'hffff_ffff;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_poke", busy, 1);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("hold_mask", doc_included, e.mask);
    chk("hold_nv", num_valid, e.nv);
  endtask

  function automatic tcand_t mk(int id, longint sc, longint ln);
    tcand_t c;
    c.id = id; c.score = sc; c.len = ln;
    return c;
  endfunction

  initial begin
    longint acc;
    int     n;
    rst_n = 1'b0;
    start = 1'b0;
    score_threshold = '0;
    token_budget = '0;
    query_length = '0;
    cand_valid = 1'b0;
    cand_id = '0;
    cand_score = '0;
    cand_length = '0;
    cand_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cand_ready, 0);
    chk("rst_nv", num_valid, 0);
    chk("rst_mask", doc_included, 0);
    chk("rst_scores_zero", longint'(|sel_scores), 0);

    // ordering
    cs.delete();
    cs.push_back(mk(1, 10, 10)); cs.push_back(mk(2, 50, 10));
    cs.push_back(mk(3, 30, 10)); cs.push_back(mk(4, 70, 10));
    cs.push_back(mk(5, 20, 10)); cs.push_back(mk(6, 60, 10));
    cs.push_back(mk(7, 40, 10));
    run_txn(0, 10000, 0, 0, 0);

    // ties keep arrival order
    cs.delete();
    cs.push_back(mk(1, 25, 5)); cs.push_back(mk(2, 25, 5));
    cs.push_back(mk(3, 25, 5));
    run_txn(0, 1000, 10, 0, 0);

    // budget skip then a later fit
    cs.delete();
    cs.push_back(mk(11, 9, 150)); cs.push_back(mk(12, 8, 200));
    cs.push_back(mk(13, 7, 80));
    run_txn(0, 400, 100, 0, 0);

    // threshold and clamp
    cs.delete();
    cs.push_back(mk(21, 60, 1000)); cs.push_back(mk(22, 40, 1000));
    run_txn(50, 4096, 0, 0, 0);

    // query alone overflows the budget
    cs.delete();
    cs.push_back(mk(31, 5, 1)); cs.push_back(mk(32, 4, 1));
    run_txn(0, 400, 399, 0, 0);

    // single beat, with a start poked during BUDGET
    cs.delete();
    cs.push_back(mk(41, 3, 20));
    run_txn(0, 100, 10, 0, 1);

    // reset in the middle of COLLECT
    wait_idle();
    do_start(0, 1000, 0);
    send_beat(mk(51, 90, 30), 0, 0, acc);
    send_beat(mk(52, 80, 30), 0, 0, acc);
    @(negedge clk);
    cand_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_nv", num_valid, 0);
    chk("abort_mask", doc_included, 0);
    chk("abort_scores_zero", longint'(|sel_scores), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // random streams
    for (int t = 0; t < 25; t++) begin
      cs.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        cs.push_back(mk(int'($urandom_range(0, 65535)),
                        longint'($urandom_range(0, 20)),
                        longint'($urandom_range(0, 700))));
      end
      run_txn(longint'($urandom_range(0, 10)),
              longint'($urandom_range(0, 1500)),
              longint'($urandom_range(0, 300)), 2, t % 7 == 3);
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    chk("pending_done", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
